gf2_poly_divider: RTL and testbench

Bit-serial GF(2)[x] long divider, the inverse companion of the 192x150 three-way Toom-Cook carry-less multiplier. It takes a 342-bit product-width dividend and a 150-bit divisor, and returns the quotient and remainder: for N = Q·D + R (XOR arithmetic), deg R < deg D. It is used to reduce multiplier outputs and to check them (dividing a·b by b returns a, remainder 0).

---
 rtl/gf2_poly_divider.sv | 171 +++++++++++++++++
 tb/tb_gf2_poly_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] long divider: n = q*d ^ r with deg r < deg d.
// Define GF2_DIV_ZERO_DETECT_EN to short-circuit a zero divisor with err=1.
//
// state   | meaning
// IDLE    | waiting for start; q/r/err hold last result
// NORM    | shifting the divisor left until its MSB is set (s counts shifts)
// DIV     | one quotient bit per edge, MSB first
// FIN     | publish q/r, pulse done, return to IDLE
module gf2_poly_divider #(
   parameter int DW = 342,
   parameter int VW = 150,
   parameter int QW = DW - VW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [DW-1:0] n_i,
   input  logic [VW-1:0] d_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [DW-1:0] q_o,
   output logic [VW-2:0] r_o
);

   localparam int SW = $clog2(VW);
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] rem_q, rem_d;
   logic [VW-1:0] div_q, div_d;
   logic [SW-1:0] s_q, s_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] quo_q, quo_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-2:0] r_q, r_d;
`ifdef GF2_DIV_ZERO_DETECT_EN
   logic          err_q, err_d;
   logic          zero_q, zero_d;
`endif

   logic          t_bit;
   logic [DW-1:0] div_aligned;

   // Gating with the divisor MSB keeps a zero divisor from copying n into q.
   assign t_bit       = rem_q[DW-1] & div_q[VW-1];
   assign div_aligned = {div_q, {(DW-VW){1'b0}}};

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      div_d   = div_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      q_d     = q_q;
      r_d     = r_q;
`ifdef GF2_DIV_ZERO_DETECT_EN
      err_d   = err_q;
      zero_d  = zero_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_NORM;
               rem_d   = n_i;
               div_d   = d_i;
               s_d     = '0;
               quo_d   = '0;
               busy_d  = 1'b1;
`ifdef GF2_DIV_ZERO_DETECT_EN
               err_d   = 1'b0;
               zero_d  = (d_i == '0);
               if (d_i == '0) begin
                  state_d = ST_FIN;
               end
`endif
            end
         end
         ST_NORM: begin
            if (div_q[VW-1] || (s_q == SW'(VW - 1))) begin
               state_d = ST_DIV;
               cnt_d   = CW'(QW) + {{(CW-SW){1'b0}}, s_q};
            end else begin
               div_d = div_q << 1;
               s_d   = s_q + 1'b1;
            end
         end
         ST_DIV: begin
            rem_d = (rem_q ^ (t_bit ? div_aligned : '0)) << 1;
            quo_d = {quo_q[DW-2:0], t_bit};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            // Remainder sits at the top of rem_q, left-shifted by the normalisation count.
            q_d     = quo_q;
            r_d     = rem_q[DW-1:DW-VW+1] >> s_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
`ifdef GF2_DIV_ZERO_DETECT_EN
            if (zero_q) begin
               q_d   = '0;
               r_d   = '0;
               err_d = 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         div_q   <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
`ifdef GF2_DIV_ZERO_DETECT_EN
         err_q   <= 1'b0;
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         q_q     <= q_d;
         r_q     <= r_d;
`ifdef GF2_DIV_ZERO_DETECT_EN
         err_q   <= err_d;
         zero_q  <= zero_d;
`endif
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign q_o    = q_q;
   assign r_o    = r_q;
`ifdef GF2_DIV_ZERO_DETECT_EN
   assign err_o  = err_q;
`else
   assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and product-reduction checks for gf2_poly_divider (quotient, remainder, latency, reset).
module tb_gf2_poly_divider;

   localparam int DW = 342;
   localparam int VW = 150;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] n;
   logic [VW-1:0] d;
   logic          busy;
   logic          done;
   logic          err;
   logic [DW-1:0] q;
   logic [VW-2:0] r;

   int checks = 0;
   int errors = 0;

   gf2_poly_divider dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start),
      .n_i     (n),
      .d_i     (d),
      .busy_o  (busy),
      .done_o  (done),
      .err_o   (err),
      .q_o     (q),
      .r_o     (r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] clmul(input logic [191:0] a, input logic [VW-1:0] b);
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < VW; i++) begin
         if (b[i]) acc = acc ^ ({{(DW-192){1'b0}}, a} << i);
      end
      return acc;
   endfunction

   // Drives one request, counts edges from the accepting edge to done, then checks results.
   task automatic do_op(input logic [DW-1:0] nv, input logic [VW-1:0] dv,
                        input logic [DW-1:0] eq, input logic [VW-2:0] er, input logic ee,
                        input int lat, input bit hold, input string tag);
      int cnt;
      bit got;
      bit busy_lost;
      start = 1'b1;
      n     = nv;
      d     = dv;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      chk({tag, "_busy0"}, DW'(busy), DW'(1));
      cnt       = 0;
      got       = 1'b0;
      busy_lost = 1'b0;
      while (!got && cnt < lat + 20) begin
         @(posedge clk); #1;
         cnt++;
         if (done) got = 1'b1;
         else if (!busy) busy_lost = 1'b1;
      end
      chk({tag, "_lat"}, got ? DW'(cnt) : '1, DW'(lat));
      chk({tag, "_busyrun"}, DW'(busy_lost), DW'(0));
      chk({tag, "_q"}, q, eq);
      chk({tag, "_r"}, DW'(r), DW'(er));
      chk({tag, "_err"}, DW'(err), DW'(ee));
      chk({tag, "_busyend"}, DW'(busy), DW'(0));
      if (!hold) begin
         @(posedge clk); #1;
         chk({tag, "_donefall"}, DW'(done), DW'(0));
      end
   endtask

   initial begin
      logic [191:0] a;
      logic [VW-1:0] b;
      logic [DW-1:0] big;
      int done_seen;

      rst_n = 1'b0;
      start = 1'b0;
      n     = '0;
      d     = '0;
      #12;
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_err", DW'(err), DW'(0));
      chk("rst_q", q, '0);
      chk("rst_r", DW'(r), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(DW'(5),    VW'(3),    DW'(3),    (VW-1)'(0), 1'b0, 491, 1'b0, "n5_d3");
      do_op(DW'(8),    VW'(3),    DW'(7),    (VW-1)'(1), 1'b0, 491, 1'b0, "n8_d3");
      do_op(DW'(5'h1F), VW'(1),   DW'(5'h1F), (VW-1)'(0), 1'b0, 493, 1'b0, "n1f_d1");
      do_op(DW'(5'h1F), VW'(5),   DW'(6),    (VW-1)'(1), 1'b0, 489, 1'b0, "n1f_d5");

      b   = '0;
      b[VW-1] = 1'b1;
      b[0]    = 1'b1;
      do_op(DW'(b) << 1, b, DW'(2), (VW-1)'(0), 1'b0, 195, 1'b0, "top_x2");

      big = '0;
      big[VW-1] = 1'b1;
      big[5]    = 1'b1;
      b   = '0;
      b[VW-1] = 1'b1;
      do_op(big, b, DW'(1), (VW-1)'(32), 1'b0, 195, 1'b0, "top_rem");

`ifdef GF2_DIV_ZERO_DETECT_EN
      do_op(DW'(5'h1F), '0, '0, '0, 1'b1, 1, 1'b0, "dzero");
`else
      do_op(DW'(5'h1F), '0, '0, '0, 1'b0, 493, 1'b0, "dzero");
`endif

      for (int i = 0; i < 200; i++) begin
         a = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         b = VW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
         b[VW-1] = 1'b1;
         do_op(clmul(a, b), b, {{(DW-192){1'b0}}, a}, '0, 1'b0, 195, 1'b1, $sformatf("rnd%0d", i));
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("b2b_donefall", DW'(done), DW'(0));

      b = '0;
      b[VW-1] = 1'b1;
      b[3]    = 1'b1;
      start = 1'b1;
      n     = {DW{1'b1}};
      d     = b;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", DW'(busy), DW'(0));
      chk("arst_done", DW'(done), DW'(0));
      chk("arst_err", DW'(err), DW'(0));
      chk("arst_q", q, '0);
      chk("arst_r", DW'(r), '0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      chk("arst_nodone", DW'(done_seen), DW'(0));

      do_op(DW'(8), VW'(3), DW'(7), (VW-1)'(1), 1'b0, 491, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
